// File: rtl/enc_pkg.sv
// enc_pkg: step codes and quadrature transition decode shared by the encoder bank.
package enc_pkg;
  typedef logic [1:0] step_t;
  localparam step_t STEP_NONE    = 2'd0;
  localparam step_t STEP_INC     = 2'd1;
  localparam step_t STEP_DEC     = 2'd2;
  localparam step_t STEP_ILLEGAL = 2'd3;
  // {A,B} -> position on the forward cycle 00,10,11,01
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] next);
    logic [1:0] d;
    d = gray_pos(next) - gray_pos(prev);
    return d == 2'd1 ? STEP_INC : d == 2'd3 ? STEP_DEC : d == 2'd2 ? STEP_ILLEGAL : STEP_NONE;
  endfunction
endpackage

// File: rtl/quad_enc_bank_if.sv
// quad_enc_bank_if: encoder pins, per-channel controls and snapshot outputs of the bank.
interface quad_enc_bank_if #(parameter int CHANNELS = 4, parameter int ENCBITS = 32);
  logic [CHANNELS-1:0]         enc_a;
  logic [CHANNELS-1:0]         enc_b;
  logic [CHANNELS-1:0]         clear;
  logic                        snapshot;
  logic [CHANNELS-1:0]         fault_clear;
  logic [CHANNELS*ENCBITS-1:0] snap_count;
  logic                        snap_valid;
  logic [CHANNELS-1:0]         faultn;
  logic [CHANNELS-1:0]         activity;
  modport master (output enc_a, enc_b, clear, snapshot, fault_clear,
                  input snap_count, snap_valid, faultn, activity);
  modport slave (input enc_a, enc_b, clear, snapshot, fault_clear,
                 output snap_count, snap_valid, faultn, activity);
endinterface

// File: rtl/quad_enc_channel.sv
// quad_enc_channel: one encoder axis - sync, glitch filter, priming, 4x decode, counter, sticky fault.
module quad_enc_channel
  import enc_pkg::*;
#(
  parameter int ENCBITS    = 32,
  parameter int FILTER_LEN = 3
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               clear,
  input  logic               fault_clear,
  output logic [ENCBITS-1:0] count,
  output logic               faultn,
  output logic               activity
);
  logic [1:0] sync1, sync2, cand, filt, prev, warm;
  logic [3:0] run, run_nxt;
  logic       fvalid, primed;
  step_t      step;
  always_comb begin
    run_nxt = sync2 != cand ? 4'd1 : run == 4'(FILTER_LEN) ? run : run + 4'd1;
    step    = primed && filt != prev ? decode_step(prev, filt) : STEP_NONE;
  end
  // warm holds the filter off until sync2 carries a real pin sample, so reset zeros never prime
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      warm   <= '0;
      cand   <= '0;
      run    <= '0;
      filt   <= '0;
      fvalid <= 1'b0;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
      if (warm[1]) begin
        cand <= sync2;
        run  <= run_nxt;
        if (run_nxt == 4'(FILTER_LEN)) begin
          filt   <= sync2;
          fvalid <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      prev     <= '0;
      primed   <= 1'b0;
      count    <= '0;
      activity <= 1'b0;
      faultn   <= 1'b1;
    end else begin
      primed   <= primed | fvalid;
      prev     <= primed || fvalid ? filt : prev;
      count    <= clear ? '0 : step == STEP_INC ? count + ENCBITS'(1) :
                  step == STEP_DEC ? count - ENCBITS'(1) : count;
      activity <= step == STEP_INC || step == STEP_DEC;
      faultn   <= step == STEP_ILLEGAL ? 1'b0 : fault_clear ? 1'b1 : faultn;
    end
  end
endmodule

// File: rtl/quad_enc_bank.sv
// quad_enc_bank: N encoder channels sharing one coherent snapshot register.
module quad_enc_bank
  import enc_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int ENCBITS    = 32,
  parameter int FILTER_LEN = 3
) (
  input logic            CLK,
  input logic            reset,
  quad_enc_bank_if.slave bus
);
  logic [CHANNELS*ENCBITS-1:0] live;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    quad_enc_channel #(.ENCBITS(ENCBITS), .FILTER_LEN(FILTER_LEN)) u_ch (
      .CLK         (CLK),
      .reset       (reset),
      .enc_a       (bus.enc_a[i]),
      .enc_b       (bus.enc_b[i]),
      .clear       (bus.clear[i]),
      .fault_clear (bus.fault_clear[i]),
      .count       (live[i*ENCBITS +: ENCBITS]),
      .faultn      (bus.faultn[i]),
      .activity    (bus.activity[i])
    );
  end
  // captures pre-update counts, so a step on the snapshot edge lands in the next snapshot
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bus.snap_count <= '0;
      bus.snap_valid <= 1'b0;
    end else begin
      bus.snap_count <= bus.snapshot ? live : bus.snap_count;
      bus.snap_valid <= bus.snapshot;
    end
  end
endmodule

// File: tb/tb_quad_enc_bank.sv
// tb_quad_enc_bank: directed tables, corner sequences and randomized moves against a position model.
module tb_quad_enc_bank;
  localparam int CH = 4;
  localparam int EB = 8;
  localparam int FL = 3;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;
  quad_enc_bank_if #(.CHANNELS(CH), .ENCBITS(EB)) bus ();
  quad_enc_bank #(.CHANNELS(CH), .ENCBITS(EB), .FILTER_LEN(FL)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );
  typedef struct {
    logic [1:0]    ab;
    int            hold;
    bit            chk;
    logic [EB-1:0] cnt;
    logic          fn;
    int            act;
  } vec_t;
  int checks = 0;
  int errors = 0;
  int act_cnt[CH];
  int pos[CH];
  logic [EB-1:0] mcnt[CH];
  logic mfn[CH];
  int mact[CH];
  logic [1:0] gtab[4];
  vec_t tbl[6];
  always @(posedge CLK) begin
    #2;
    for (int i = 0; i < CH; i++) if (bus.activity[i]) act_cnt[i]++;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [EB-1:0] cnt(input int c);
    return bus.snap_count[c*EB +: EB];
  endfunction
  task automatic setab(input int c, input logic [1:0] ab);
    bus.enc_a[c] = ab[1];
    bus.enc_b[c] = ab[0];
  endtask
  task automatic snap();
    bus.snapshot = 1'b1;
    cyc(1);
    bus.snapshot = 1'b0;
  endtask
  // d: +1 forward, -1 reverse, 2 illegal jump
  task automatic move(input int c, input int d, input int hold);
    pos[c] = (pos[c] + d + 4) % 4;
    if (d == 2) mfn[c] = 1'b0;
    else begin
      mcnt[c] = mcnt[c] + EB'(d);
      mact[c]++;
    end
    setab(c, gtab[pos[c]]);
    cyc(hold);
  endtask
  task automatic check_all(input string tag);
    snap();
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s_cnt%0d", tag, c), cnt(c), mcnt[c]);
      chk($sformatf("%s_faultn%0d", tag, c), bus.faultn[c], mfn[c]);
      chk($sformatf("%s_act%0d", tag, c), act_cnt[c], mact[c]);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mcnt[c] = '0;
      mfn[c] = 1'b1;
      mact[c] = 0;
      act_cnt[c] = 0;
    end
  endtask
  initial begin
    logic [EB-1:0] old;
    int lat;
    int act[CH];
    int glen;
    gtab[0] = 2'b00; gtab[1] = 2'b10; gtab[2] = 2'b11; gtab[3] = 2'b01;
    tbl[0] = '{2'b01, 2, 1'b0, 8'h00, 1'b1, 0};
    tbl[1] = '{2'b11, 10, 1'b1, 8'h00, 1'b1, 0};
    tbl[2] = '{2'b10, 10, 1'b1, 8'hFF, 1'b1, 1};
    tbl[3] = '{2'b00, 10, 1'b1, 8'hFE, 1'b1, 2};
    tbl[4] = '{2'b11, 10, 1'b1, 8'hFE, 1'b0, 2};
    tbl[5] = '{2'b01, 10, 1'b1, 8'hFF, 1'b0, 3};
    bus.enc_a = '1;
    bus.enc_b = '1;
    bus.clear = '0;
    bus.snapshot = 1'b0;
    bus.fault_clear = '0;
    model_reset();
    for (int c = 0; c < CH; c++) pos[c] = 2;
    cyc(3);
    chk("rst_snap_count", bus.snap_count, 0);
    chk("rst_snap_valid", bus.snap_valid, 0);
    chk("rst_faultn", bus.faultn, 4'hF);
    chk("rst_activity", bus.activity, 0);
    reset = 1'b0;
    cyc(10);
    check_all("powerup");
    // ch0: first step latency, then 32 forward and 32 reverse
    pos[0] = 3;
    setab(0, gtab[3]);
    mcnt[0]++;
    mact[0]++;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (bus.activity[0] && lat == 0) lat = i;
    end
    chk("latency", lat, 6);
    for (int i = 0; i < 31; i++) move(0, 1, 10);
    check_all("fwd32");
    for (int i = 0; i < 32; i++) move(0, -1, 10);
    check_all("rev32");
    // ch1: signed wrap
    for (int i = 0; i < 127; i++) move(1, 1, 6);
    snap();
    chk("ch1_max", cnt(1), 8'h7F);
    move(1, 1, 6);
    snap();
    chk("ch1_wrap_min", cnt(1), 8'h80);
    move(1, -1, 6);
    check_all("ch1_wrap_back");
    // ch2: glitch rejection and illegal jumps from the table
    for (int i = 0; i < 6; i++) begin
      setab(2, tbl[i].ab);
      cyc(tbl[i].hold);
      if (tbl[i].chk) begin
        snap();
        chk($sformatf("tbl%0d_cnt", i), cnt(2), tbl[i].cnt);
        chk($sformatf("tbl%0d_faultn", i), bus.faultn[2], tbl[i].fn);
        chk($sformatf("tbl%0d_act", i), act_cnt[2], tbl[i].act);
      end
    end
    pos[2] = 3; mcnt[2] = 8'hFF; mfn[2] = 1'b0; mact[2] = 3;
    bus.fault_clear[2] = 1'b1;
    cyc(1);
    bus.fault_clear[2] = 1'b0;
    mfn[2] = 1'b1;
    chk("fault_clear", bus.faultn[2], 1);
    move(2, 2, 5);
    bus.fault_clear[2] = 1'b1;
    cyc(1);
    bus.fault_clear[2] = 1'b0;
    chk("fault_wins", bus.faultn[2], 0);
    cyc(4);
    check_all("fault_sticky");
    // ch3: clear beats a simultaneous step
    for (int i = 0; i < 5; i++) move(3, 1, 6);
    snap();
    chk("ch3_five", cnt(3), 5);
    move(3, 1, 5);
    bus.clear[3] = 1'b1;
    cyc(1);
    bus.clear[3] = 1'b0;
    mcnt[3] = '0;
    chk("clear_act", bus.activity[3], 1);
    cyc(2);
    check_all("clear_wins");
    // snapshot on the same edge as a ch0 step 9->10
    for (int i = 0; i < 9; i++) move(0, 1, 6);
    old = mcnt[0];
    move(0, 1, 5);
    bus.snapshot = 1'b1;
    cyc(1);
    bus.snapshot = 1'b0;
    chk("snap_valid_hi", bus.snap_valid, 1);
    chk("snap_step_act", bus.activity[0], 1);
    chk("snap_pre_step", cnt(0), old);
    for (int c = 1; c < CH; c++) chk($sformatf("snap_coh%0d", c), cnt(c), mcnt[c]);
    cyc(1);
    chk("snap_valid_lo", bus.snap_valid, 0);
    bus.snapshot = 1'b1;
    cyc(1);
    chk("b2b_valid0", bus.snap_valid, 1);
    cyc(1);
    bus.snapshot = 1'b0;
    chk("b2b_valid1", bus.snap_valid, 1);
    chk("b2b_cnt", cnt(0), mcnt[0]);
    cyc(1);
    chk("b2b_valid_lo", bus.snap_valid, 0);
    // async reset in the middle of a move
    setab(0, gtab[(pos[0] + 1) % 4]);
    cyc(3);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_count", bus.snap_count, 0);
    chk("mid_rst_valid", bus.snap_valid, 0);
    chk("mid_rst_faultn", bus.faultn, 4'hF);
    chk("mid_rst_act", bus.activity, 0);
    model_reset();
    for (int c = 0; c < CH; c++) begin
      pos[c] = $urandom_range(0, 3);
      setab(c, gtab[pos[c]]);
    end
    cyc(2);
    reset = 1'b0;
    cyc(12);
    check_all("reprime");
    // randomized moves, glitches and illegal jumps
    for (int s = 0; s < 60; s++) begin
      glen = $urandom_range(1, 2);
      for (int c = 0; c < CH; c++) begin
        act[c] = $urandom_range(0, 9);
        if (act[c] < 4) move(c, 1, 0);
        else if (act[c] < 8) move(c, -1, 0);
        else if (act[c] == 8) move(c, 2, 0);
        else setab(c, gtab[(pos[c] + 1) % 4]);
      end
      cyc(glen);
      for (int c = 0; c < CH; c++) if (act[c] == 9) setab(c, gtab[pos[c]]);
      cyc(8 - glen);
      if (s % 10 == 9) check_all($sformatf("rand%0d", s));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
